// File: rtl/char_glyph_server.sv
// Glyph bitmap RAM with a per-line fetch FSM that serves one 8-pixel row to charHandler.
// Optional `GLYPH_MIRROR_EN adds a mirror input that horizontally flips the fetched row.
module char_glyph_server #(
    parameter int unsigned GLYPHS = 4,
    parameter int unsigned GSEL_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              readEn,
    input  logic [3:0]        rowCnt,
    input  logic [2:0]        colCnt,
    input  logic [GSEL_W-1:0] charSel,
`ifdef GLYPH_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic              wrEn,
    input  logic [GSEL_W-1:0] wrGlyph,
    input  logic [3:0]        wrRow,
    input  logic [7:0]        wrData,
    input  logic              clrErr,
    output logic              bitDisp,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, READY} state_t;

    state_t              state_q, state_d;
    logic [GSEL_W+3:0]   addr_q, addr_d;
    logic                sel_ok_q, sel_ok_d;
    logic [7:0]          line_q, line_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          rdata_q;
    logic [7:0]          load_word;
    logic                wr_ok;
    logic                sel_ok;

    logic [7:0] mem [GLYPHS*16];

    // Indices at or above GLYPHS only exist when GLYPHS is not a power of two.
    assign wr_ok  = ({1'b0, wrGlyph} < (GSEL_W+1)'(GLYPHS));
    assign sel_ok = ({1'b0, charSel} < (GSEL_W+1)'(GLYPHS));

    // Read and write share an edge, so a same-address write returns the old word.
    always_ff @(posedge clock) begin
        if (wrEn && wr_ok) begin
            mem[{wrGlyph, wrRow}] <= wrData;
        end
        if (state_q == FETCH) begin
            rdata_q <= sel_ok_q ? mem[addr_q] : '0;
        end
    end

`ifdef GLYPH_MIRROR_EN
    logic mirror_q, mirror_d;
    logic [7:0] rdata_rev;

    always_comb begin
        rdata_rev = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            rdata_rev[i] = rdata_q[7-i];
        end
    end

    assign load_word = mirror_q ? rdata_rev : rdata_q;

    always_comb begin
        mirror_d = mirror_q;
        if ((state_q == IDLE || state_q == READY) && readEn) begin
            mirror_d = mirror;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mirror_q <= 1'b0;
        end else begin
            mirror_q <= mirror_d;
        end
    end
`else
    assign load_word = rdata_q;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_ok_d  = sel_ok_q;
        line_d    = line_q;
        overrun_d = overrun_q;

        if (clrErr) begin
            overrun_d = 1'b0;
        end
        if (readEn && (state_q == FETCH || state_q == LOAD)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE, READY: begin
                if (readEn) begin
                    state_d  = FETCH;
                    addr_d   = {charSel, rowCnt};
                    sel_ok_d = sel_ok;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                line_d  = load_word;
                state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sel_ok_q  <= 1'b0;
            line_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_ok_q  <= sel_ok_d;
            line_q    <= line_d;
            overrun_q <= overrun_d;
        end
    end

    // Column 0 is the leftmost pixel, held in bit 7.
    assign bitDisp = (state_q == READY) && line_q[~colCnt];
    assign busy    = (state_q == FETCH) || (state_q == LOAD);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_char_glyph_server.sv
// Directed bench for char_glyph_server; covers the mirror option when `GLYPH_MIRROR_EN is defined.
module tb_char_glyph_server;

    logic       clock;
    logic       reset;
    logic       readEn;
    logic [3:0] rowCnt;
    logic [2:0] colCnt;
    logic [1:0] charSel;
    logic       mirror;
    logic       wrEn;
    logic [1:0] wrGlyph;
    logic [3:0] wrRow;
    logic [7:0] wrData;
    logic       clrErr;
    logic       bitDisp;
    logic       busy;
    logic       overrun;

    int tests_run;
    int tests_failed;

    char_glyph_server #(.GLYPHS(4), .GSEL_W(2)) dut (
        .clock   (clock),
        .reset   (reset),
        .readEn  (readEn),
        .rowCnt  (rowCnt),
        .colCnt  (colCnt),
        .charSel (charSel),
`ifdef GLYPH_MIRROR_EN
        .mirror  (mirror),
`endif
        .wrEn    (wrEn),
        .wrGlyph (wrGlyph),
        .wrRow   (wrRow),
        .wrData  (wrData),
        .clrErr  (clrErr),
        .bitDisp (bitDisp),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_row(input logic [1:0] g, input logic [3:0] r, input logic [7:0] d);
        wrEn = 1'b1; wrGlyph = g; wrRow = r; wrData = d;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (bitDisp !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: bitDisp=%b busy=%b overrun=%b, required 0 0 0", bitDisp, busy, overrun);
        end
        reset = 1'b1;
        tick();
        write_row(2'd0, 4'd0, 8'h00);
        write_row(2'd1, 4'd3, 8'hA5);
        write_row(2'd2, 4'd5, 8'h1E);
        write_row(2'd0, 4'd9, 8'hC3);
    endtask

    task automatic test_basic_fetch();
        logic [7:0] exp;
        exp = 8'hA5;
        charSel = 2'd1; rowCnt = 4'd3; readEn = 1'b1;
        tick();
        readEn = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || bitDisp !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_fetch_cycle: busy=%b bitDisp=%b, required 1 0", busy, bitDisp);
        end
        tick();
        tests_run++;
        if (busy !== 1'b1 || bitDisp !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_load_cycle: busy=%b bitDisp=%b, required 1 0", busy, bitDisp);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ready_busy: busy=%b, required 0", busy);
        end
        // A write elsewhere must leave the served line alone.
        write_row(2'd3, 4'd2, 8'hFF);
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            #1;
            tests_run++;
            if (bitDisp !== exp[7-c]) begin
                tests_failed++;
                $display("FAIL basic_col%0d: bitDisp=%b, required %b", c, bitDisp, exp[7-c]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        exp = 8'hA5;
        charSel = 2'd1; rowCnt = 4'd3; readEn = 1'b1;
        tick();
        charSel = 2'd0; rowCnt = 4'd0;
        tick();
        readEn = 1'b0;
        tests_run++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set: overrun=%b busy=%b, required 1 1", overrun, busy);
        end
        tick();
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            #1;
            tests_run++;
            if (bitDisp !== exp[7-c]) begin
                tests_failed++;
                $display("FAIL overrun_line_col%0d: bitDisp=%b, required %b", c, bitDisp, exp[7-c]);
            end
        end
        tick();
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
        end
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_latched_addr();
        logic [7:0] exp;
        exp = 8'h1E;
        charSel = 2'd2; rowCnt = 4'd5; readEn = 1'b1;
        tick();
        readEn = 1'b0; charSel = 2'd0; rowCnt = 4'd9;
        tick();
        tick();
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            #1;
            tests_run++;
            if (bitDisp !== exp[7-c]) begin
                tests_failed++;
                $display("FAIL latched_col%0d: bitDisp=%b, required %b", c, bitDisp, exp[7-c]);
            end
        end
    endtask

    task automatic test_collision();
        charSel = 2'd0; rowCnt = 4'd0; readEn = 1'b1;
        tick();
        readEn = 1'b0;
        write_row(2'd0, 4'd0, 8'hFF);
        tick();
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            #1;
            tests_run++;
            if (bitDisp !== 1'b0) begin
                tests_failed++;
                $display("FAIL collision_old_col%0d: bitDisp=%b, required 0", c, bitDisp);
            end
        end
        // Back-to-back fetch straight from READY.
        readEn = 1'b1;
        tick();
        readEn = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            #1;
            tests_run++;
            if (bitDisp !== 1'b1) begin
                tests_failed++;
                $display("FAIL collision_new_col%0d: bitDisp=%b, required 1", c, bitDisp);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] exp;
        exp = 8'hA5;
        colCnt = 3'd0;
        charSel = 2'd1; rowCnt = 4'd3; readEn = 1'b1;
        tick();
        readEn = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (bitDisp !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_load: bitDisp=%b busy=%b overrun=%b, required 0 0 0", bitDisp, busy, overrun);
        end
        #1;
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bitDisp !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: bitDisp=%b busy=%b, required 0 0", bitDisp, busy);
        end
        readEn = 1'b1;
        tick();
        readEn = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            #1;
            tests_run++;
            if (bitDisp !== exp[7-c]) begin
                tests_failed++;
                $display("FAIL after_reset_col%0d: bitDisp=%b, required %b", c, bitDisp, exp[7-c]);
            end
        end
    endtask

`ifdef GLYPH_MIRROR_EN
    task automatic test_mirror();
        write_row(2'd3, 4'd1, 8'h80);
        for (int m = 0; m < 2; m++) begin
            charSel = 2'd3; rowCnt = 4'd1; mirror = (m == 1); readEn = 1'b1;
            tick();
            readEn = 1'b0; mirror = 1'b0;
            tick();
            tick();
            for (int c = 0; c < 8; c++) begin
                colCnt = 3'(c);
                #1;
                tests_run++;
                if (bitDisp !== ((m == 1) ? (c == 7) : (c == 0))) begin
                    tests_failed++;
                    $display("FAIL mirror%0d_col%0d: bitDisp=%b, required %b", m, c, bitDisp,
                             ((m == 1) ? (c == 7) : (c == 0)));
                end
            end
        end
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0; readEn = 1'b0; rowCnt = '0; colCnt = '0; charSel = '0;
        mirror = 1'b0; wrEn = 1'b0; wrGlyph = '0; wrRow = '0; wrData = '0; clrErr = 1'b0;
        test_reset();
        test_basic_fetch();
        test_overrun();
        test_latched_addr();
        test_collision();
        test_reset_mid_load();
`ifdef GLYPH_MIRROR_EN
        test_mirror();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
